sd_spi_card_controller: RTL and testbench

- Sequences the SD-card SPI-mode emulation.
- Consumes command frames decoded by the SPI receiver and tracks the card init state (power-up, idle, ready) and the CMD55 application-command prefix.
- Owns the data block size fed back to the receiver.
- Emits the R1/R3/R7 response byte stream to the SPI transmitter over a valid/ready byte handshake.

---
 rtl/sd_spi_card_controller_if.sv | 21 ++
 rtl/sd_spi_card_controller.sv | 189 ++++++++++++++++++
 tb/tb_sd_spi_card_controller.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/sd_spi_card_controller_if.sv
// Command/response channel between the SPI receiver/transmitter and the SD card controller.
// master: drives command frames and accepts response bytes; slave: the card controller.
interface sd_spi_card_controller_if;
    logic        cmd_valid;
    logic        cmd_error;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output cmd_valid, cmd_error, cmd_index, cmd_arg, tx_ready,
        input  tx_data, tx_valid
    );

    modport slave (
        input  cmd_valid, cmd_error, cmd_index, cmd_arg, tx_ready,
        output tx_data, tx_valid
    );
endinterface

// File: rtl/sd_spi_card_controller.sv
// SD-card SPI-mode command sequencer: tracks init state and the ACMD prefix, owns the
// data block size, and streams R1/R3/R7 responses (with NCR filler) over valid/ready.
module sd_spi_card_controller #(
    parameter int NCR_BYTES  = 1,
    parameter int INIT_POLLS = 2,
    parameter int MAX_BLOCK  = 2048,
    parameter int DEF_BLOCK  = 512
) (
    input  logic                            clock,
    input  logic                            reset,
    sd_spi_card_controller_if.slave         bus,
    output logic [11:0]                     block_size,
    output logic                            card_ready,
    output logic                            app_cmd,
    output logic                            busy
);

    typedef enum logic [1:0] {CARD_PWRUP, CARD_IDLE, CARD_READY} card_state_e;
    typedef enum logic [1:0] {RSP_WAIT, RSP_NCR, RSP_RESP}       rsp_state_e;

    localparam logic [2:0] NCR_LAST = 3'(NCR_BYTES == 0 ? 0 : NCR_BYTES - 1);

    card_state_e       card_state_q, card_state_d;
    logic [3:0]        poll_q, poll_d;
    logic              app_cmd_q, app_cmd_d;
    logic [11:0]       block_size_q, block_size_d;

    rsp_state_e        rsp_state_q, rsp_state_d;
    logic [2:0]        ncr_cnt_q, ncr_cnt_d;
    logic [2:0]        byte_idx_q, byte_idx_d;
    logic [2:0]        resp_last_q, resp_last_d;
    logic [4:0][7:0]   resp_q, resp_d;

    logic              start;
    logic              illegal, crc_err, param_err;

    // Command decode: card state updates and response composition.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        card_state_d = card_state_q;
        poll_d       = poll_q;
        app_cmd_d    = app_cmd_q;
        block_size_d = block_size_q;
        resp_d       = '0;
        resp_last_d  = 3'd0;
        start        = 1'b0;
        illegal      = 1'b0;
        crc_err      = 1'b0;
        param_err    = 1'b0;

        if (!busy) begin
            if (bus.cmd_error) begin
                app_cmd_d = 1'b0;
                if (card_state_q != CARD_PWRUP) begin
                    start   = 1'b1;
                    crc_err = 1'b1;
                end
            end else if (bus.cmd_valid) begin
                app_cmd_d = 1'b0;
                if (card_state_q != CARD_PWRUP || bus.cmd_index == 6'd0) begin
                    start = 1'b1;
                    case (bus.cmd_index)
                        6'd0: begin
                            card_state_d = CARD_IDLE;
                            poll_d       = 4'd0;
                            block_size_d = 12'(DEF_BLOCK);
                        end
                        6'd8: begin
                            resp_d[3]   = {4'h0, bus.cmd_arg[11:8]};
                            resp_d[4]   = bus.cmd_arg[7:0];
                            resp_last_d = 3'd4;
                        end
                        6'd55: app_cmd_d = 1'b1;
                        6'd41: begin
                            if (!app_cmd_q) begin
                                illegal = 1'b1;
                            end else if (card_state_q == CARD_IDLE) begin
                                if (poll_q < 4'(INIT_POLLS)) poll_d = poll_q + 4'd1;
                                if (poll_d == 4'(INIT_POLLS)) card_state_d = CARD_READY;
                            end
                        end
                        6'd16: begin
                            if (bus.cmd_arg >= 32'd1 && bus.cmd_arg <= 32'(MAX_BLOCK))
                                block_size_d = bus.cmd_arg[11:0];
                            else
                                param_err = 1'b1;
                        end
                        6'd58: begin
                            resp_d[1]   = {card_state_q == CARD_READY, 7'b0};
                            resp_d[2]   = 8'hFF;
                            resp_d[3]   = 8'h80;
                            resp_last_d = 3'd4;
                        end
                        default: illegal = 1'b1;
                    endcase
                end
            end
        end
        resp_d[0] = {1'b0, param_err, 2'b00, crc_err, illegal, 1'b0, card_state_d == CARD_IDLE};
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            card_state_q <= CARD_PWRUP;
            poll_q       <= 4'd0;
            app_cmd_q    <= 1'b0;
            block_size_q <= 12'(DEF_BLOCK);
            resp_last_q  <= 3'd0;
        end else begin
            card_state_q <= card_state_d;
            poll_q       <= poll_d;
            app_cmd_q    <= app_cmd_d;
            block_size_q <= block_size_d;
            if (start) resp_last_q <= resp_last_d;
        end
    end

    // NOTE: the response buffer is only read after a start loads it, so it carries no reset.
    always_ff @(posedge clock) begin
        if (start) resp_q <= resp_d;
    end

    // Response FSM: state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rsp_state_q <= RSP_WAIT;
            ncr_cnt_q   <= 3'd0;
            byte_idx_q  <= 3'd0;
        end else begin
            rsp_state_q <= rsp_state_d;
            ncr_cnt_q   <= ncr_cnt_d;
            byte_idx_q  <= byte_idx_d;
        end
    end

    // Response FSM: next state; a byte advances only on a valid/ready handshake.
    always_comb begin
        rsp_state_d = rsp_state_q;
        ncr_cnt_d   = ncr_cnt_q;
        byte_idx_d  = byte_idx_q;
        case (rsp_state_q)
            RSP_WAIT: begin
                if (start) begin
                    rsp_state_d = (NCR_BYTES == 0) ? RSP_RESP : RSP_NCR;
                    ncr_cnt_d   = 3'd0;
                    byte_idx_d  = 3'd0;
                end
            end
            RSP_NCR: begin
                if (bus.tx_ready) begin
                    ncr_cnt_d = ncr_cnt_q + 3'd1;
                    if (ncr_cnt_q == NCR_LAST) rsp_state_d = RSP_RESP;
                end
            end
            RSP_RESP: begin
                if (bus.tx_ready) begin
                    byte_idx_d = byte_idx_q + 3'd1;
                    if (byte_idx_q == resp_last_q) rsp_state_d = RSP_WAIT;
                end
            end
            default: rsp_state_d = RSP_WAIT;
        endcase
    end

    // Response FSM: outputs.
    always_comb begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'hFF;
        busy         = 1'b0;
        case (rsp_state_q)
            RSP_NCR: begin
                bus.tx_valid = 1'b1;
                busy         = 1'b1;
            end
            RSP_RESP: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = resp_q[byte_idx_q];
                busy         = 1'b1;
            end
            default: ;
        endcase
    end

    assign block_size = block_size_q;
    assign card_ready = (card_state_q == CARD_READY);
    assign app_cmd    = app_cmd_q;

endmodule

// File: tb/tb_sd_spi_card_controller.sv
// Scoreboard bench for sd_spi_card_controller: expected response bytes are queued when a
// command is driven and compared as each byte is handed off on the tx handshake.
module tb_sd_spi_card_controller;

    localparam int NCR = 1;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] block_size;
    logic        card_ready;
    logic        app_cmd;
    logic        busy;

    sd_spi_card_controller_if bif ();

    sd_spi_card_controller #(
        .NCR_BYTES (NCR),
        .INIT_POLLS(2),
        .MAX_BLOCK (2048),
        .DEF_BLOCK (512)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bif),
        .block_size(block_size),
        .card_ready(card_ready),
        .app_cmd   (app_cmd),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Monitor: a byte is taken at the next rising edge when valid and ready are both high.
    always @(negedge clock) begin
        if (reset === 1'b1 && bif.tx_valid === 1'b1 && bif.tx_ready === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_byte", 32'(bif.tx_valid), 32'd0);
            else                   check("resp_byte", 32'(bif.tx_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic expect_r1(input logic [7:0] r1);
        for (int i = 0; i < NCR; i++) exp_q.push_back(8'hFF);
        exp_q.push_back(r1);
    endtask

    task automatic expect_long(input logic [7:0] b0, b1, b2, b3, b4);
        for (int i = 0; i < NCR; i++) exp_q.push_back(8'hFF);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        exp_q.push_back(b3);
        exp_q.push_back(b4);
    endtask

    // Drives one command cycle; called one time unit after a rising edge.
    task automatic send(input logic [5:0] idx, input logic [31:0] arg,
                        input bit v, input bit e, input bit accepted);
        bif.cmd_index = idx;
        bif.cmd_arg   = arg;
        bif.cmd_valid = v;
        bif.cmd_error = e;
        @(posedge clock);
        #1;
        bif.cmd_valid = 1'b0;
        bif.cmd_error = 1'b0;
        if (accepted) begin
            check("busy_rise", 32'(busy), 32'd1);
            check("tx_valid_rise", 32'(bif.tx_valid), 32'd1);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
        check("busy_fall", 32'(busy), 32'd0);
    endtask

    task automatic wait_q_le(input int lim);
        int n = 0;
        while (exp_q.size() > lim && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("wait_q", 32'(exp_q.size() <= lim), 32'd1);
    endtask

    task automatic run_cmd_r1(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] r1);
        expect_r1(r1);
        send(idx, arg, 1'b1, 1'b0, 1'b1);
        drain();
    endtask

    initial begin
        reset         = 1'b0;
        bif.tx_ready  = 1'b1;
        bif.cmd_valid = 1'b0;
        bif.cmd_error = 1'b0;
        bif.cmd_index = '0;
        bif.cmd_arg   = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_tx_valid", 32'(bif.tx_valid), 32'd0);
        check("rst_tx_data", 32'(bif.tx_data), 32'hFF);
        reset = 1'b1;
        check("rst_block", 32'(block_size), 32'd512);
        check("rst_card_ready", 32'(card_ready), 32'd0);
        check("rst_app_cmd", 32'(app_cmd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Power-up: everything except CMD0 is ignored, including frame errors.
        send(6'd8, 32'h1AA, 1'b1, 1'b0, 1'b0);
        send(6'd8, 32'h1AA, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("pwrup_quiet", 32'(bif.tx_valid), 32'd0);
            @(posedge clock);
            #1;
        end
        check("pwrup_card_ready", 32'(card_ready), 32'd0);
        check("pwrup_block", 32'(block_size), 32'd512);

        run_cmd_r1(6'd0, 32'h0, 8'h01);
        expect_long(8'h01, 8'h00, 8'h00, 8'h01, 8'hAA);
        send(6'd8, 32'h0000_01AA, 1'b1, 1'b0, 1'b1);
        drain();

        // Init polling: ready on the second ACMD41.
        run_cmd_r1(6'd55, 32'h0, 8'h01);
        check("app_cmd_set", 32'(app_cmd), 32'd1);
        run_cmd_r1(6'd41, 32'h4000_0000, 8'h01);
        check("app_cmd_clr", 32'(app_cmd), 32'd0);
        check("poll1_not_ready", 32'(card_ready), 32'd0);
        run_cmd_r1(6'd55, 32'h0, 8'h01);
        run_cmd_r1(6'd41, 32'h4000_0000, 8'h00);
        check("poll2_ready", 32'(card_ready), 32'd1);
        expect_long(8'h00, 8'h80, 8'hFF, 8'h80, 8'h00);
        send(6'd58, 32'h0, 1'b1, 1'b0, 1'b1);
        drain();

        // Block length range, including out-of-range upper argument bits.
        run_cmd_r1(6'd16, 32'd1024, 8'h00);
        check("blk_1024", 32'(block_size), 32'd1024);
        run_cmd_r1(6'd16, 32'd4096, 8'h40);
        check("blk_4096_rej", 32'(block_size), 32'd1024);
        run_cmd_r1(6'd16, 32'h0001_0400, 8'h40);
        check("blk_upper_rej", 32'(block_size), 32'd1024);
        run_cmd_r1(6'd16, 32'd0, 8'h40);
        check("blk_zero_rej", 32'(block_size), 32'd1024);
        run_cmd_r1(6'd16, 32'd2048, 8'h00);
        check("blk_max", 32'(block_size), 32'd2048);

        run_cmd_r1(6'd0, 32'h0, 8'h01);
        check("cmd0_block", 32'(block_size), 32'd512);
        check("cmd0_not_ready", 32'(card_ready), 32'd0);

        // Stall mid-R7; a CMD55 arriving while busy must be dropped.
        expect_long(8'h01, 8'h00, 8'h00, 8'h05, 8'hC3);
        send(6'd8, 32'h0000_05C3, 1'b1, 1'b0, 1'b1);
        wait_q_le(4);
        bif.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bif.cmd_index = 6'd55;
            bif.cmd_valid = (i == 1);
            check("stall_data", 32'(bif.tx_data), 32'(exp_q[0]));
            check("stall_valid", 32'(bif.tx_valid), 32'd1);
            @(posedge clock);
            #1;
        end
        bif.cmd_valid = 1'b0;
        bif.tx_ready  = 1'b1;
        drain();
        check("dropped_cmd55", 32'(app_cmd), 32'd0);

        run_cmd_r1(6'd41, 32'h0, 8'h05);
        run_cmd_r1(6'd12, 32'h0, 8'h05);

        // Error and valid together: error wins, CMD16 must not take effect.
        expect_r1(8'h09);
        send(6'd16, 32'd1024, 1'b1, 1'b1, 1'b1);
        drain();
        check("err_wins_block", 32'(block_size), 32'd512);
        run_cmd_r1(6'd16, 32'd1024, 8'h01);
        check("idle_blk_1024", 32'(block_size), 32'd1024);

        // Reset in the middle of an R7.
        expect_long(8'h01, 8'h00, 8'h00, 8'h01, 8'hAA);
        send(6'd8, 32'h0000_01AA, 1'b1, 1'b0, 1'b1);
        wait_q_le(3);
        reset = 1'b0;
        exp_q.delete();
        @(posedge clock);
        #1;
        check("midrst_tx_valid", 32'(bif.tx_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_block", 32'(block_size), 32'd512);
        check("midrst_card_ready", 32'(card_ready), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check("post_rst_quiet", 32'(bif.tx_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
